regfile_mp: RTL and testbench

- Multi-port, parametrised integer register file for the core's decode/writeback stages.
- Provides N combinational read ports and M write ports, with same-cycle write-to-read bypass and an optional hardwired zero register.
- Replaces the bulk async reset clear with a synchronous sequential clear sweep that reports completion.
- Optionally tracks per-register pending-write state (scoreboard) for the hazard unit.

---
 rtl/regfile_pkg.sv | 31 +++
 rtl/regfile_bypass_mux.sv | 55 +++++
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The sweep FSM state and the write-port priority pick live here.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  localparam int MAX_WR_PORTS = 16;

  // Highest-index set bit of a write-match vector, or -1 if none.
  function automatic int hi_match(
    input logic [MAX_WR_PORTS-1:0] hits
  );
    int idx;
    idx = -1;
    for (int i = 0; i < MAX_WR_PORTS; i++) begin
      if (hits[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic addr_ok(
    input int a,
    input int n
  );
    return a < n;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: same-cycle write bypass in front of the storage.
// Optional hit output (REGFILE_SCOREBOARD_EN) masks pending flags.
import regfile_pkg::*;

module regfile_bypass_mux #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int NUM_WR_PORTS  = 1,
  parameter int ZERO_REG      = 1,
  parameter int AW            = $clog2(NUM_REGISTERS)
) (
  input  logic                               active,
  input  logic [AW-1:0]                      addr,
  input  logic [NUM_WR_PORTS-1:0]            wr_ok,
  input  logic [NUM_WR_PORTS*AW-1:0]         wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0]              regs [NUM_REGISTERS],
  output logic [DATA_WIDTH-1:0]              data
`ifdef REGFILE_SCOREBOARD_EN
  ,
  output logic                               hit
`endif
);

  logic [MAX_WR_PORTS-1:0] hits;
  logic                    any_hit;
  logic                    rd_legal;
  int                      sel;

  always_comb begin
    hits = '0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      hits[p] = wr_ok[p] && (wr_addr[p*AW +: AW] == addr);
    end
    sel      = hi_match(hits);
    any_hit  = (sel >= 0);
    rd_legal = addr_ok(int'(addr), NUM_REGISTERS) &&
               !((ZERO_REG != 0) && (addr == '0));
    data     = '0;
    if (active) begin
      if (any_hit) begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (p == sel) data = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (rd_legal) begin
        data = regs[addr];
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  assign hit = any_hit;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a synchronous clear sweep after reset.
// Define REGFILE_SCOREBOARD_EN to add the pending-write scoreboard.
import regfile_pkg::*;

module regfile_mp #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int NUM_RD_PORTS  = 2,
  parameter int NUM_WR_PORTS  = 1,
  parameter int ZERO_REG      = 1,
  localparam int AW           = $clog2(NUM_REGISTERS)
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               init_done,
  input  logic [NUM_WR_PORTS-1:0]            wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0]         wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD_PORTS*AW-1:0]         rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                               sb_set_en,
  input  logic [AW-1:0]                      sb_set_addr,
  output logic [NUM_RD_PORTS-1:0]            rd_pending
`endif
);

  rf_state_t                 state;
  logic [AW-1:0]             clr_idx;
  logic [DATA_WIDTH-1:0]     regs [NUM_REGISTERS];
  logic [NUM_WR_PORTS-1:0]   wr_ok;
  logic                      ready;

  assign ready = (state == RF_READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RF_CLEAR;
      clr_idx   <= '0;
      init_done <= 1'b0;
    end else if (state == RF_CLEAR) begin
      if (clr_idx == AW'(NUM_REGISTERS - 1)) begin
        state     <= RF_READY;
        init_done <= 1'b1;
      end else begin
        clr_idx <= clr_idx + AW'(1);
      end
    end
  end

  // Writes only count once ready, to a real register, never to x0.
  always_comb begin
    wr_ok = '0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      wr_ok[p] = ready && wr_en[p] &&
        addr_ok(int'(wr_addr[p*AW +: AW]), NUM_REGISTERS) &&
        !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
    end
  end

  // Later ports overwrite earlier ones: highest index wins.
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      regs[clr_idx] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_ok[p]) begin
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NUM_REGISTERS-1:0] pending;
  logic [NUM_RD_PORTS-1:0]  rd_hit;

  // Set is applied last so a new producer beats a retiring write.
  always_ff @(posedge clk) begin
    if (rst || state == RF_CLEAR) begin
      pending <= '0;
    end else begin
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_ok[p]) pending[wr_addr[p*AW +: AW]] <= 1'b0;
      end
      if (sb_set_en &&
          addr_ok(int'(sb_set_addr), NUM_REGISTERS) &&
          !((ZERO_REG != 0) && (sb_set_addr == '0))) begin
        pending[sb_set_addr] <= 1'b1;
      end
    end
  end
`endif

  for (genvar r = 0; r < NUM_RD_PORTS; r++) begin : g_rd
    regfile_bypass_mux #(
      .DATA_WIDTH   (DATA_WIDTH),
      .NUM_REGISTERS(NUM_REGISTERS),
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .ZERO_REG     (ZERO_REG),
      .AW           (AW)
    ) u_mux (
      .active (ready),
      .addr   (rd_addr[r*AW +: AW]),
      .wr_ok  (wr_ok),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .regs   (regs),
      .data   (rd_data[r*DATA_WIDTH +: DATA_WIDTH])
`ifdef REGFILE_SCOREBOARD_EN
      ,
      .hit    (rd_hit[r])
`endif
    );

`ifdef REGFILE_SCOREBOARD_EN
    assign rd_pending[r] = ready &&
      addr_ok(int'(rd_addr[r*AW +: AW]), NUM_REGISTERS) &&
      pending[rd_addr[r*AW +: AW]] && !rd_hit[r];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table plus clear/reset sequences.
// Scoreboard checks run when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        init_done;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;

  logic        init24;
  logic        w24_en = 1'b0;
  logic [4:0]  w24_addr = '0;
  logic [31:0] w24_data = '0;
  logic [4:0]  r24_addr = '0;
  logic [31:0] r24_data;

`ifdef REGFILE_SCOREBOARD_EN
  logic        sb_set_en = 1'b0;
  logic [4:0]  sb_set_addr = '0;
  logic [1:0]  rd_pending;
  logic        sb24_en = 1'b0;
  logic [4:0]  sb24_addr = '0;
  logic        pend24;
`endif

  regfile_mp #(
    .DATA_WIDTH(32), .NUM_REGISTERS(32), .NUM_RD_PORTS(2),
    .NUM_WR_PORTS(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef REGFILE_SCOREBOARD_EN
    , .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .rd_pending(rd_pending)
`endif
  );

  regfile_mp #(
    .DATA_WIDTH(32), .NUM_REGISTERS(24), .NUM_RD_PORTS(1),
    .NUM_WR_PORTS(1), .ZERO_REG(1)
  ) dut24 (
    .clk(clk), .rst(rst), .init_done(init24),
    .wr_en(w24_en), .wr_addr(w24_addr), .wr_data(w24_data),
    .rd_addr(r24_addr), .rd_data(r24_data)
`ifdef REGFILE_SCOREBOARD_EN
    , .sb_set_en(sb24_en), .sb_set_addr(sb24_addr),
    .rd_pending(pend24)
`endif
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
  } vec_t;

  vec_t tv [13];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    wr_data = '0;
    wr_addr = '0;
  endtask

  // Count edges until init_done while hammering a write to x3.
  task automatic wait_ready(output int n, output logic leak);
    n = 0;
    leak = 1'b0;
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {32'd0, 32'h99};
    rd_addr = {5'd3, 5'd5};
    while (!init_done && n < 200) begin
      #1;
      if (!init_done && rd_data != '0) leak = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    idle();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int   n;
  logic leak;

  initial begin
    tv[0]  = '{2'b01, 5'd7,  5'd0,  32'h1234, 32'h0,  5'd7,  5'd7,  32'h1234, 32'h1234};
    tv[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  5'd7,  5'd7,  32'h1234, 32'h1234};
    tv[2]  = '{2'b11, 5'd3,  5'd3,  32'hAAAA, 32'h5555, 5'd3, 5'd7, 32'h5555, 32'h1234};
    tv[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  5'd3,  5'd3,  32'h5555, 32'h5555};
    tv[4]  = '{2'b01, 5'd0,  5'd0,  32'hFFFF, 32'h0,  5'd0,  5'd0,  32'h0,    32'h0};
    tv[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  5'd0,  5'd7,  32'h0,    32'h1234};
    tv[6]  = '{2'b11, 5'd10, 5'd11, 32'h1,    32'h2,  5'd10, 5'd11, 32'h1,    32'h2};
    tv[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  5'd11, 5'd10, 32'h2,    32'h1};
    tv[8]  = '{2'b11, 5'd12, 5'd10, 32'h7,    32'hCAFE, 5'd12, 5'd10, 32'h7,  32'hCAFE};
    tv[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  5'd10, 5'd12, 32'hCAFE, 32'h7};
    tv[10] = '{2'b10, 5'd20, 5'd0,  32'h5,    32'hFFFF, 5'd20, 5'd0,  32'h0,  32'h0};
    tv[11] = '{2'b11, 5'd30, 5'd31, 32'h1,    32'hFFFFFFFF, 5'd31, 5'd30,
               32'hFFFFFFFF, 32'h1};
    tv[12] = '{2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  5'd30, 5'd31, 32'h1,
               32'hFFFFFFFF};

    // Power-on reset and first sweep.
    rst = 1'b1;
    tick();
    tick();
    chk("reset_init_done", {63'd0, init_done}, 64'd0);
    chk("reset_rd_zero", rd_data, 64'd0);
    rst = 1'b0;
    wait_ready(n, leak);
    chk("first_sweep_cycles", n, 32);
    chk("first_sweep_rd_zero", {63'd0, leak}, 64'd0);
    chk("x3_after_clear", {32'd0, rd_data[31:0]}, 64'd0);

    for (int i = 0; i < 13; i++) begin
      wr_en   = tv[i].we;
      wr_addr = {tv[i].wa1, tv[i].wa0};
      wr_data = {tv[i].wd1, tv[i].wd0};
      rd_addr = {tv[i].ra1, tv[i].ra0};
      #1;
      chk($sformatf("vec%0d", i), rd_data, {tv[i].e1, tv[i].e0});
      @(posedge clk);
      #1;
    end
    idle();

    // Illegal addresses on a 24-entry file.
    chk("init24", {63'd0, init24}, 64'd1);
    w24_en = 1'b1; w24_addr = 5'd30; w24_data = 32'h55;
    r24_addr = 5'd30;
    #1;
    chk("ill_rd_same", {32'd0, r24_data}, 64'd0);
    tick();
    w24_addr = 5'd23; w24_data = 32'hABC;
    #1;
    chk("ill_rd_after", {32'd0, r24_data}, 64'd0);
    r24_addr = 5'd23;
    #1;
    chk("last_legal_bypass", {32'd0, r24_data}, 64'hABC);
    tick();
    w24_en = 1'b0;
    #1;
    chk("last_legal_stored", {32'd0, r24_data}, 64'hABC);

`ifdef REGFILE_SCOREBOARD_EN
    rd_addr = {5'd0, 5'd9};
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    #1;
    chk("sb_not_yet", {62'd0, rd_pending}, 64'd0);
    tick();
    sb_set_en = 1'b0;
    #1;
    chk("sb_set", {62'd0, rd_pending}, 64'd1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'h42};
    #1;
    chk("sb_hidden", {62'd0, rd_pending}, 64'd0);
    chk("sb_bypass", {32'd0, rd_data[31:0]}, 64'h42);
    tick();
    idle();
    #1;
    chk("sb_cleared", {62'd0, rd_pending}, 64'd0);
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h43, 32'd0};
    tick();
    idle();
    sb_set_addr = 5'd0;
    tick();
    sb_set_en = 1'b0;
    #1;
    chk("sb_set_wins", {62'd0, rd_pending}, 64'd1);
    chk("sb_x0_never", {62'd0, rd_pending}, 64'd1);
`endif

    // Preload then clear via a one-cycle reset pulse.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
    tick();
    idle();
    rd_addr = {5'd5, 5'd5};
    #1;
    chk("preload_x5", rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
    pulse_rst();
    chk("pulse_init_low", {63'd0, init_done}, 64'd0);
    wait_ready(n, leak);
    chk("pulse_sweep_cycles", n, 32);
    chk("pulse_rd_zero", {63'd0, leak}, 64'd0);
    #1;
    chk("x5_x3_cleared", rd_data, 64'd0);
`ifdef REGFILE_SCOREBOARD_EN
    rd_addr = {5'd0, 5'd9};
    #1;
    chk("sb_cleared_by_rst", {62'd0, rd_pending}, 64'd0);
`endif

    // Reset mid-sweep restarts the count.
    pulse_rst();
    for (int i = 0; i < 10; i++) tick();
    chk("mid_init_low", {63'd0, init_done}, 64'd0);
    pulse_rst();
    wait_ready(n, leak);
    chk("mid_sweep_cycles", n, 32);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
